// File: rtl/gpio_bscan_pkg.sv
// Shared constants and helpers for the GPIO boundary-scan segment.
// Cell offsets within one pad's 3-bit group, update-register reset values, DR strobe decode.
package gpio_bscan_pkg;

    localparam int BSC_IN            = 0;
    localparam int BSC_OUT           = 1;
    localparam int BSC_OE            = 2;
    localparam int BSC_CELLS_PER_PAD = 3;

    localparam logic UPD_OE_RST  = 1'b1;
    localparam logic UPD_OUT_RST = 1'b0;

    typedef enum logic [1:0] {
        OP_HOLD    = 2'd0,
        OP_CAPTURE = 2'd1,
        OP_SHIFT   = 2'd2,
        OP_UPDATE  = 2'd3
    } dr_op_e;

    // Colliding strobes resolve as capture > shift > update; only one acts per cycle.
    function automatic dr_op_e dr_op_sel(input logic capture, input logic shift,
                                         input logic update);
        dr_op_e op;
        if (capture) begin
            op = OP_CAPTURE;
        end else if (shift) begin
            op = OP_SHIFT;
        end else if (update) begin
            op = OP_UPDATE;
        end else begin
            op = OP_HOLD;
        end
        return op;
    endfunction

endpackage

// File: rtl/gpio_bscan_sync.sv
// Multi-flop synchronizer bringing asynchronous pad DI into the clk domain.
// SYNC_STAGES must be at least 2.
module gpio_bscan_sync
    import gpio_bscan_pkg::*;
#(
    parameter int NUM_PADS    = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_PADS-1:0] async_in,
    output logic [NUM_PADS-1:0] sync_out
);

    logic [SYNC_STAGES-1:0][NUM_PADS-1:0] sync_q;
    logic [SYNC_STAGES-1:0][NUM_PADS-1:0] sync_d;

    // Next state: shift the raw input into stage 0 and advance every stage.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
    end

    // Stage registers; reset clears the whole pipe.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {(SYNC_STAGES*NUM_PADS){1'b0}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/gpio_bscan_seg.sv
// Boundary-scan segment for a row of GPIO pads: 3 cells per pad (IN, OUT, OE),
// OUT/OE update register, and the functional/EXTEST output mux.
module gpio_bscan_seg
    import gpio_bscan_pkg::*;
#(
    parameter int NUM_PADS    = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                shift_dr,
    input  logic                capture_dr,
    input  logic                update_dr,
    input  logic                extest,
    input  logic                tdi,
    output logic                tdo,
    input  logic [NUM_PADS-1:0] core_do,
    input  logic [NUM_PADS-1:0] core_oen,
    input  logic [NUM_PADS-1:0] core_ie,
    output logic [NUM_PADS-1:0] core_di,
    output logic [NUM_PADS-1:0] pad_do,
    output logic [NUM_PADS-1:0] pad_oen,
    output logic [NUM_PADS-1:0] pad_ie,
    output logic [NUM_PADS-1:0] pad_bsen,
    input  logic [NUM_PADS-1:0] pad_di
);

    localparam int CHAIN_LEN = BSC_CELLS_PER_PAD * NUM_PADS;

    logic [CHAIN_LEN-1:0] sr_q;
    logic [CHAIN_LEN-1:0] sr_d;
    logic [NUM_PADS-1:0]  upd_out_q;
    logic [NUM_PADS-1:0]  upd_out_d;
    logic [NUM_PADS-1:0]  upd_oe_q;
    logic [NUM_PADS-1:0]  upd_oe_d;
    logic [NUM_PADS-1:0]  di_sync;
    dr_op_e               dr_op;

    gpio_bscan_sync #(
        .NUM_PADS    (NUM_PADS),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (pad_di),
        .sync_out (di_sync)
    );

    assign dr_op = dr_op_sel(capture_dr, shift_dr, update_dr);

    // Output mux: the capture path below samples these muxed values, not the core inputs.
    always_comb begin
        if (extest) begin
            pad_do  = upd_out_q;
            pad_oen = upd_oe_q;
        end else begin
            pad_do  = core_do;
            pad_oen = core_oen;
        end
        pad_ie   = core_ie;
        pad_bsen = {NUM_PADS{extest}};
    end

    // Next state for the scan chain and the OUT/OE update register.
    always_comb begin
        sr_d      = sr_q;
        upd_out_d = upd_out_q;
        upd_oe_d  = upd_oe_q;
        case (dr_op)
            OP_CAPTURE: begin
                for (int i = 0; i < NUM_PADS; i++) begin
                    sr_d[BSC_CELLS_PER_PAD*i + BSC_IN]  = di_sync[i];
                    sr_d[BSC_CELLS_PER_PAD*i + BSC_OUT] = pad_do[i];
                    sr_d[BSC_CELLS_PER_PAD*i + BSC_OE]  = pad_oen[i];
                end
            end
            OP_SHIFT: begin
                sr_d = {tdi, sr_q[CHAIN_LEN-1:1]};
            end
            OP_UPDATE: begin
                for (int i = 0; i < NUM_PADS; i++) begin
                    upd_out_d[i] = sr_q[BSC_CELLS_PER_PAD*i + BSC_OUT];
                    upd_oe_d[i]  = sr_q[BSC_CELLS_PER_PAD*i + BSC_OE];
                end
            end
            OP_HOLD: begin
                sr_d = sr_q;
            end
            default: begin
                sr_d = sr_q;
            end
        endcase
    end

    // Chain and update registers; reset leaves every pad high-Z under EXTEST.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q      <= {CHAIN_LEN{1'b0}};
            upd_out_q <= {NUM_PADS{UPD_OUT_RST}};
            upd_oe_q  <= {NUM_PADS{UPD_OE_RST}};
        end else begin
            sr_q      <= sr_d;
            upd_out_q <= upd_out_d;
            upd_oe_q  <= upd_oe_d;
        end
    end

    assign tdo     = sr_q[0];
    assign core_di = di_sync;

endmodule

// File: tb/tb_gpio_bscan_seg.sv
// Self-checking bench for gpio_bscan_seg: directed test plan plus randomized traffic
// compared every cycle against a behavioural model of the chain, update register and sync delay.
module tb_gpio_bscan_seg;

    localparam int NP = 2;
    localparam int SS = 2;
    localparam int L  = 3 * NP;

    logic          clk = 1'b0;
    logic          rst, shift_dr, capture_dr, update_dr, extest, tdi;
    logic          tdo;
    logic [NP-1:0] core_do, core_oen, core_ie, core_di;
    logic [NP-1:0] pad_do, pad_oen, pad_ie, pad_bsen, pad_di;

    int checks = 0;
    int errors = 0;

    gpio_bscan_seg #(.NUM_PADS(NP), .SYNC_STAGES(SS)) dut (
        .clk        (clk),
        .rst        (rst),
        .shift_dr   (shift_dr),
        .capture_dr (capture_dr),
        .update_dr  (update_dr),
        .extest     (extest),
        .tdi        (tdi),
        .tdo        (tdo),
        .core_do    (core_do),
        .core_oen   (core_oen),
        .core_ie    (core_ie),
        .core_di    (core_di),
        .pad_do     (pad_do),
        .pad_oen    (pad_oen),
        .pad_ie     (pad_ie),
        .pad_bsen   (pad_bsen),
        .pad_di     (pad_di)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: chain as a plain bit array, pad_di delay as a queue.
    bit            chain [L];
    bit [NP-1:0]   m_out, m_oe;
    bit [NP-1:0]   dq [$];
    bit            m_valid = 1'b0;

    function automatic bit [NP-1:0] exp_pad_do();
        return extest ? m_out : core_do;
    endfunction

    function automatic bit [NP-1:0] exp_pad_oen();
        return extest ? m_oe : core_oen;
    endfunction

    always @(posedge clk) begin
        bit [NP-1:0] pdo, poen;
        if (rst) begin
            for (int k = 0; k < L; k++) chain[k] = 1'b0;
            m_out = '0;
            m_oe  = '1;
            dq.delete();
            for (int s = 0; s < SS; s++) dq.push_back('0);
            m_valid = 1'b1;
        end else if (m_valid) begin
            pdo  = exp_pad_do();
            poen = exp_pad_oen();
            if (capture_dr) begin
                for (int i = 0; i < NP; i++) begin
                    chain[3*i]   = dq[0][i];
                    chain[3*i+1] = pdo[i];
                    chain[3*i+2] = poen[i];
                end
            end else if (shift_dr) begin
                for (int k = 0; k < L-1; k++) chain[k] = chain[k+1];
                chain[L-1] = tdi;
            end else if (update_dr) begin
                for (int i = 0; i < NP; i++) begin
                    m_out[i] = chain[3*i+1];
                    m_oe[i]  = chain[3*i+2];
                end
            end
            dq.push_back(pad_di);
            void'(dq.pop_front());
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("tdo",      {31'd0, tdo},        {31'd0, chain[0]});
            chk("core_di",  {30'd0, core_di},    {30'd0, dq[0]});
            chk("pad_do",   {30'd0, pad_do},     {30'd0, exp_pad_do()});
            chk("pad_oen",  {30'd0, pad_oen},    {30'd0, exp_pad_oen()});
            chk("pad_ie",   {30'd0, pad_ie},     {30'd0, core_ie});
            chk("pad_bsen", {30'd0, pad_bsen},   {30'd0, {NP{extest}}});
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        logic [5:0] exp_seq;
        logic [5:0] preload;

        rst = 1'b1; shift_dr = 1'b0; capture_dr = 1'b0; update_dr = 1'b0;
        extest = 1'b1; tdi = 1'b0;
        core_do = '0; core_oen = '0; core_ie = 2'b01; pad_di = '0;
        tick(2);
        chk("rst_pad_oen",  {30'd0, pad_oen},  32'h3);
        chk("rst_pad_do",   {30'd0, pad_do},   32'h0);
        chk("rst_tdo",      {31'd0, tdo},      32'h0);
        chk("rst_pad_bsen", {30'd0, pad_bsen}, 32'h3);
        rst = 1'b0;

        // Functional passthrough and synchronizer latency
        extest = 1'b0; core_do = 2'b10; core_oen = 2'b01; pad_di = 2'b11;
        #1;
        chk("func_pad_do",  {30'd0, pad_do},  32'h2);
        chk("func_pad_oen", {30'd0, pad_oen}, 32'h1);
        chk("sync_lat0",    {30'd0, core_di}, 32'h0);
        tick();
        chk("sync_lat1",    {30'd0, core_di}, 32'h0);
        tick();
        chk("sync_lat2",    {30'd0, core_di}, 32'h3);

        // Capture then shift out
        core_do = 2'b01; core_oen = 2'b10; pad_di = 2'b10;
        tick(3);
        capture_dr = 1'b1;
        tick();
        capture_dr = 1'b0;
        shift_dr = 1'b1;
        tdi = 1'b0;
        exp_seq = 6'b101010;
        for (int k = 0; k < L; k++) begin
            chk($sformatf("cap_tdo%0d", k), {31'd0, tdo}, {31'd0, exp_seq[k]});
            tick();
        end
        shift_dr = 1'b0;

        // Preload pad1 OE=0 OUT=1 IN=1, pad0 OE=0 OUT=0 IN=1, then update into EXTEST
        preload = 6'b011001;
        shift_dr = 1'b1;
        for (int k = 0; k < L; k++) begin
            tdi = preload[k];
            tick();
        end
        shift_dr = 1'b0;
        update_dr = 1'b1;
        tick();
        update_dr = 1'b0;
        extest = 1'b1;
        #1;
        chk("ext_pad_oen", {30'd0, pad_oen}, 32'h0);
        chk("ext_pad_do",  {30'd0, pad_do},  32'h2);
        shift_dr = 1'b1; tdi = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("ext_hold%0d", k), {30'd0, pad_do}, 32'h2);
        end
        shift_dr = 1'b0;

        // Strobe collision: only capture acts
        pad_di = 2'b01;
        tick(3);
        capture_dr = 1'b1; shift_dr = 1'b1; update_dr = 1'b1;
        tick();
        capture_dr = 1'b0; shift_dr = 1'b0; update_dr = 1'b0;
        #1;
        chk("coll_tdo",     {31'd0, tdo},     32'h1);
        chk("coll_pad_do",  {30'd0, pad_do},  32'h2);
        chk("coll_pad_oen", {30'd0, pad_oen}, 32'h0);

        // Reset mid-shift discards partial contents
        shift_dr = 1'b1; tdi = 1'b1;
        tick(3);
        shift_dr = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0; shift_dr = 1'b1; tdi = 1'b0;
        for (int k = 0; k < L; k++) begin
            chk($sformatf("rstmid_tdo%0d", k), {31'd0, tdo}, 32'h0);
            tick();
        end
        shift_dr = 1'b0;
        chk("rstmid_pad_oen", {30'd0, pad_oen}, 32'h3);
        chk("rstmid_pad_do",  {30'd0, pad_do},  32'h0);

        // Randomized traffic checked every cycle by the model
        for (int n = 0; n < 3000; n++) begin
            rst        = ($urandom_range(0, 249) == 0);
            capture_dr = ($urandom_range(0, 9) == 0);
            shift_dr   = ($urandom_range(0, 2) == 0);
            update_dr  = ($urandom_range(0, 7) == 0);
            tdi        = 1'($urandom);
            core_do    = 2'($urandom);
            core_oen   = 2'($urandom);
            core_ie    = 2'($urandom);
            pad_di     = 2'($urandom);
            if ($urandom_range(0, 19) == 0) extest = ~extest;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
